// File: rtl/layer0_input_packer.sv
// -----------------------------------------------------------------------------
// layer0_input_packer
//
// Quantises a stream of signed I/Q readout samples into 2-bit codes against
// three ascending thresholds and packs one frame of N_IN codes into a single
// output word for the layer-0 LUT neurons. Sample k of a frame lands in
// out_data[2k+1:2k]. A frame closes on the N_IN-th sample or earlier on
// in_last; early frames are zero-padded and flagged with frame_short.
//
// One completed frame can wait in the fill buffer (HOLD) while the output
// register is still occupied. Input is stalled only in that state, so the
// block sustains one sample per cycle when out_ready stays high.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_data      signed sample (SAMPLE_W)
//   in_valid     sample valid
//   in_ready     sample accept (low only while a finished frame waits)
//   in_last      final sample of a frame
//   thr          {thr2, thr1, thr0}, signed, thr0 in the LSBs
//   out_data     packed 2-bit codes (2*N_IN)
//   out_valid    packed frame valid
//   out_ready    downstream accept
//   frame_short  frame closed early by in_last
//   clip_cnt     (optional) saturating count of full-scale samples
//
// Optional feature macro: LAYER0_INPUT_PACKER_CLIP_CNT_EN adds clip_cnt.
// -----------------------------------------------------------------------------
module layer0_input_packer #(
    parameter int N_IN     = 32,
    parameter int SAMPLE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SAMPLE_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [3*SAMPLE_W-1:0] thr,
    output logic [2*N_IN-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_short
`ifdef LAYER0_INPUT_PACKER_CLIP_CNT_EN
    ,
    output logic [15:0]           clip_cnt
`endif
);

    localparam int CNT_W = $clog2(N_IN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Threshold quantiser: signed compares against the three ascending levels.
    function automatic logic [1:0] quantize(
        input logic signed [SAMPLE_W-1:0] s,
        input logic [3*SAMPLE_W-1:0]      t
    );
        logic signed [SAMPLE_W-1:0] t0;
        logic signed [SAMPLE_W-1:0] t1;
        logic signed [SAMPLE_W-1:0] t2;
        t0 = t[SAMPLE_W-1:0];
        t1 = t[2*SAMPLE_W-1:SAMPLE_W];
        t2 = t[3*SAMPLE_W-1:2*SAMPLE_W];
        if (s < t0)      quantize = 2'd0;
        else if (s < t1) quantize = 2'd1;
        else if (s < t2) quantize = 2'd2;
        else             quantize = 2'd3;
    endfunction

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [2*N_IN-1:0]       acc_q;
    logic [3*SAMPLE_W-1:0]   thr_q;
    logic                    pend_short_q;
    logic [2*N_IN-1:0]       out_data_q;
    logic                    out_valid_q;
    logic                    frame_short_q;

    logic                    accept;
    logic                    close;
    logic                    out_free;
    logic                    short_d;
    logic [1:0]              code_d;
    logic [2*N_IN-1:0]       frame_d;

    assign in_ready    = (state_q != HOLD);
    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign frame_short = frame_short_q;

    always_comb begin
        accept   = in_valid && in_ready;
        close    = accept && ((cnt_q == LAST_IDX) || in_last);
        short_d  = (cnt_q != LAST_IDX);
        // Output register can take a frame this cycle if empty or draining.
        out_free = !out_valid_q || out_ready;
        // The first sample of a frame is coded with the live thresholds,
        // which are latched alongside it for the rest of the frame.
        code_d   = quantize($signed(in_data), (state_q == IDLE) ? thr : thr_q);
        // Starting from zero guarantees 00 in slots an early close leaves unfilled.
        frame_d  = (state_q == IDLE) ? '0 : acc_q;
        frame_d[{cnt_q, 1'b0} +: 2] = code_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            frame_short_q <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE, FILL: begin
                    if (accept) begin
                        if (state_q == IDLE) begin
                            thr_q <= thr;
                        end
                        if (close) begin
                            cnt_q <= '0;
                            if (out_free) begin
                                // Direct load; overrides the drain clear so a
                                // drain and a close in the same cycle leave no bubble.
                                out_data_q    <= frame_d;
                                frame_short_q <= short_d;
                                out_valid_q   <= 1'b1;
                                state_q       <= IDLE;
                            end else begin
                                acc_q        <= frame_d;
                                pend_short_q <= short_d;
                                state_q      <= HOLD;
                            end
                        end else begin
                            acc_q   <= frame_d;
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= FILL;
                        end
                    end
                end
                HOLD: begin
                    // out_valid is always set here; its transfer frees the register.
                    if (out_ready) begin
                        out_data_q    <= acc_q;
                        frame_short_q <= pend_short_q;
                        out_valid_q   <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LAYER0_INPUT_PACKER_CLIP_CNT_EN
    localparam logic [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic [15:0] clip_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_q <= '0;
        end else if (accept && ((in_data == S_MIN) || (in_data == S_MAX))
                     && (clip_q != 16'hFFFF)) begin
            clip_q <= clip_q + 16'd1;
        end
    end

    assign clip_cnt = clip_q;
`endif

endmodule

// File: doc/layer0_input_packer.md
LAYER0_INPUT_PACKER -- requirements
Module: layer0_input_packer

Interface
REQ-001 SHALL have parameter N_IN, default 32, meaning samples per frame (range 2..64).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning signed readout-sample width.
REQ-003 SHALL have port clk  input  1  clock; the block SHALL use this single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  SAMPLE_W  signed I/Q readout sample.
REQ-006 SHALL have port in_valid  input  1  sample-valid qualifier.
REQ-007 SHALL have port in_ready  output  1  sample-accept indication.
REQ-008 SHALL have port in_last  input  1  marks the final sample of a frame.
REQ-009 SHALL have port thr  input  3*SAMPLE_W  three signed ascending thresholds; thr0 in the LSBs.
REQ-010 SHALL have port out_data  output  2*N_IN  packed 2-bit codes for the layer-0 LUT neurons.
REQ-011 SHALL have port out_valid  output  1  packed-frame valid.
REQ-012 SHALL have port out_ready  input  1  downstream accept.
REQ-013 SHALL have port frame_short  output  1  qualifies out_data: frame closed early by in_last.

Function
REQ-014 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-015 Code assignment per sample, signed compare: 0 if s<thr0; 1 if thr0<=s<thr1; 2 if thr1<=s<thr2; 3 otherwise.
REQ-016 thr SHALL be latched on the first accepted sample of each frame and held for the rest of that frame.
REQ-017 The k-th accepted sample of a frame (k from 0) SHALL occupy out_data[2k+1:2k].
REQ-018 FSM states: IDLE (no samples held), FILL (1..N_IN-1 samples held), HOLD (frame complete, output register occupied).
REQ-019 Transitions: IDLE->FILL on first accept; FILL->IDLE when the frame closes and the output register is empty or being drained that cycle; FILL->HOLD when the frame closes while the output register is occupied and not draining; HOLD->IDLE when the output transfer occurs.
REQ-020 A frame SHALL close on the N_IN-th accepted sample, or on an earlier accepted sample with in_last=1.
REQ-021 On an early close, unfilled code slots SHALL be 00 and frame_short SHALL be 1.
REQ-022 in_last=0 on the N_IN-th sample SHALL still close the frame with frame_short=0.
REQ-023 Latency: frame closes at edge t -> out_valid=1 from cycle t+1, provided the output register is free.
REQ-024 in_ready SHALL be 0 only in HOLD, so the block sustains one sample per cycle with out_ready held high.
REQ-025 out_data and frame_short SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 A simultaneous output drain and frame close SHALL load the new frame with no bubble: out_valid stays 1.

Reset
REQ-027 rst=1 SHALL force: state IDLE, sample count 0, out_valid=0, out_data=0, frame_short=0, in_ready=1 on the following cycle.
REQ-028 rst asserted mid-frame or mid-hold SHALL discard all partial and pending frames without emitting them.

Configuration
REQ-029 Macro LAYER0_INPUT_PACKER_CLIP_CNT_EN: when defined, the block SHALL add output clip_cnt (16 bits). It counts accepted samples equal to the most-negative or most-positive SAMPLE_W value, saturates at 0xFFFF, and is cleared by rst. When undefined, the port and its logic SHALL be absent.

Verification
REQ-030 N_IN=4, thr={-100,0,100}, samples -200,-50,50,200 with out_ready=1 -> out_data=8'b11_10_01_00, frame_short=0, one cycle after the 4th accept.
REQ-031 Samples 150,150 with in_last on the 2nd -> out_data=8'b0000_1111, frame_short=1.
REQ-032 out_ready=0 for 20 cycles with continuous input -> second frame completes, in_ready=0 in HOLD, first frame unchanged; out_ready=1 -> both frames delivered in order with no loss.
REQ-033 thr changed mid-frame -> codes of the current frame use the old thr; the next frame uses the new thr.
REQ-034 rst pulsed after 2 of 4 samples, then 4 fresh samples -> exactly one frame emitted, containing only the fresh codes.
REQ-035 With LAYER0_INPUT_PACKER_CLIP_CNT_EN, samples 0x8000, 0x7FFF, 0x0000 -> clip_cnt=2.
